// File: rtl/sisc_seq.sv
// SISC multi-cycle sequencer: fetch handshake, pc/ir ownership,
// phase strobes, branch resolution and halt.
module sisc_seq #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic                mem_ready,
  input  logic [31:0]         mem_rdata,
  input  logic [3:0]          stat,
  output logic                mem_req,
  output logic [PC_WIDTH-1:0] mem_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [31:0]         ir,
  output logic                exec_en,
  output logic                wb_en,
  output logic                halted,
  output logic [31:0]         retired
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]         ir_q, ir_d;
  logic [31:0]         ret_q, ret_d;

  logic [3:0]          op;
  logic [3:0]          mm;
  logic                taken;
  logic                is_nop;
  logic                is_bra;
  logic                is_brr;
  logic                is_hlt;
  logic [31:0]         ofs;
  logic [PC_WIDTH-1:0] bra_tgt;
  logic [PC_WIDTH-1:0] brr_tgt;

  assign op      = ir_q[31:28];
  assign mm      = ir_q[27:24];
  assign is_nop  = (op == 4'h0);
  assign is_bra  = (op == 4'h2);
  assign is_brr  = (op == 4'h3);
  assign is_hlt  = (op == 4'hF);
  assign taken   = (mm == 4'b0000) | (|(mm & stat));
  assign ofs     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign bra_tgt = ir_q[PC_WIDTH-1:0];
  assign brr_tgt = pc_q + ofs[PC_WIDTH-1:0];

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign retired  = ret_q;

  // Next-state, datapath updates and phase strobes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    mem_req = 1'b0;
    exec_en = 1'b0;
    wb_en   = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        state_d = is_hlt ? HALT : EXEC;
      end
      EXEC: begin
        exec_en = 1'b1;
        state_d = WB;
        unique case (1'b1)
          is_nop: begin
            ret_d   = ret_q + 32'd1;
            state_d = FETCH;
          end
          is_bra: begin
            if (taken) pc_d = bra_tgt;
            ret_d   = ret_q + 32'd1;
            state_d = FETCH;
          end
          is_brr: begin
            if (taken) pc_d = brr_tgt;
            ret_d   = ret_q + 32'd1;
            state_d = FETCH;
          end
          default: ;
        endcase
      end
      WB: begin
        wb_en   = 1'b1;
        ret_d   = ret_q + 32'd1;
        state_d = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // State register; reset overrides any in-flight update.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
    end
  end

endmodule
